// File: rtl/pcie_flow_ctrl.sv
// Flow-control and configuration controller for the device-1 switch layer.
// Sequences reset/init/idle/active/error and arbitrates P0/P1 FIFO pops.
module pcie_flow_ctrl #(
    parameter int DATA_SIZE  = 10,
    parameter int MAIN_SIZE  = 8,
    parameter int TH_WIDTH   = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic [TH_WIDTH-1:0] th_almost_full_in,
    input  logic [TH_WIDTH-1:0] th_almost_empty_in,
    input  logic                fifo_empty0,
    input  logic                fifo_empty1,
    input  logic                fifo_error0,
    input  logic                fifo_error1,
    input  logic                down_almostfull0,
    input  logic                down_almostfull1,
    output logic                pop_0,
    output logic                pop_1,
    output logic [TH_WIDTH-1:0] th_almost_full,
    output logic [TH_WIDTH-1:0] th_almost_empty,
    output logic [2:0]          state,
    output logic                idle,
    output logic                error_out
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

    // Informational parameters only bound the legal configuration space.
    if (STARVE_MAX < 1 || STARVE_MAX > 15 || MAIN_SIZE < 2 || DATA_SIZE < 1) begin : g_param_check
        $error("pcie_flow_ctrl: parameter out of range");
    end

    state_t              state_q, state_d;
    logic [TH_WIDTH-1:0] th_af_q, th_af_d;
    logic [TH_WIDTH-1:0] th_ae_q, th_ae_d;
    logic [3:0]          starve_q, starve_d;

    logic err;
    logic elig0, elig1;
    logic grant0, grant1;
    logic active;

    assign err    = fifo_error0 | fifo_error1;
    assign active = (state_q == ST_ACTIVE);
    assign elig0  = ~fifo_empty0 & ~down_almostfull0;
    assign elig1  = ~fifo_empty1 & ~down_almostfull1;
    assign grant1 = elig1 & (~elig0 | (starve_q == STARVE_MAX_C));
    assign grant0 = elig0 & ~grant1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RESET;
            th_af_q  <= '0;
            th_ae_q  <= '0;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            th_af_q  <= th_af_d;
            th_ae_q  <= th_ae_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d = state_q;
        th_af_d = th_af_q;
        th_ae_d = th_ae_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_INIT;
                th_af_d = '0;
                th_ae_d = '0;
            end
            ST_INIT: begin
                // Errors are deliberately ignored while thresholds are configured.
                th_af_d = th_almost_full_in;
                th_ae_d = th_almost_empty_in;
                if (!init) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (err) begin
                    state_d = ST_ERROR;
                end else if (init) begin
                    state_d = ST_INIT;
                end else if (!fifo_empty0 || !fifo_empty1) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (err) begin
                    state_d = ST_ERROR;
                end else if (init) begin
                    state_d = ST_INIT;
                end else if (fifo_empty0 && fifo_empty1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Starvation counter: counts P0 wins while P1 waits, saturating at STARVE_MAX.
    always_comb begin
        starve_d = starve_q;
        if (!active || grant1 || !elig1) begin
            starve_d = 4'd0;
        end else if (grant0 && (starve_q < STARVE_MAX_C)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    assign pop_0           = active & grant0 & ~err;
    assign pop_1           = active & grant1 & ~err;
    assign th_almost_full  = th_af_q;
    assign th_almost_empty = th_ae_q;
    assign state           = state_q;
    assign idle            = (state_q == ST_IDLE);
    assign error_out       = (state_q == ST_ERROR);

endmodule

// File: doc/pcie_flow_ctrl.md
# pcie_flow_ctrl

Flow-control and configuration controller for the device-1 layer of the adaptive PCIe switch. It sequences the layer through reset, threshold initialisation, idle and active phases, and latches the FIFO almost-full/almost-empty thresholds during initialisation. It also arbitrates pops from the two class FIFOs (fifo0 = P0, fifo1 = P1) against downstream almost-full backpressure, using a starvation guard for P1. It sits between the class-switching FIFOs and the router, and drives their `pop_0`/`pop_1`.

## Interface
Parameters:
- `DATA_SIZE`, 10, word width of the switched datapath (informational; no datapath passes through this block)
- `MAIN_SIZE`, 8, FIFO depth (informational; bounds the threshold range)
- `TH_WIDTH`, 3, threshold width
- `STARVE_MAX`, 4, consecutive P0 grants tolerated while P1 is eligible; valid range 1..15

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `init`  in  1  request for the initialisation phase
- `th_almost_full_in`  in  TH_WIDTH  almost-full threshold to configure
- `th_almost_empty_in`  in  TH_WIDTH  almost-empty threshold to configure
- `fifo_empty0`, `fifo_empty1`  in  1 each  class FIFO empty flags
- `fifo_error0`, `fifo_error1`  in  1 each  class FIFO overflow/underflow flags
- `down_almostfull0`, `down_almostfull1`  in  1 each  downstream almost-full for path 0 and path 1
- `pop_0`, `pop_1`  out  1 each  pop strobes to the class FIFOs
- `th_almost_full`, `th_almost_empty`  out  TH_WIDTH each  latched thresholds
- `state`  out  3  current FSM state
- `idle`  out  1  high in IDLE
- `error_out`  out  1  high in ERROR

## Operation
- Reset is synchronous and active-high. While `reset`=1 at a rising edge, the registers load `state`=RESET, thresholds=0 and `starve_cnt`=0. `pop_0`, `pop_1`, `idle` and `error_out` are 0 while in RESET.
- State encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4. Values 5–7 are illegal and recover to RESET on the next edge.
- Transition priority in IDLE and ACTIVE: error, then `init`, then the remaining rules. `err` = `fifo_error0` | `fifo_error1`.
- RESET → INIT unconditionally on the first edge with `reset`=0.
- INIT:
  - The threshold registers load `th_*_in` on every edge while in INIT.
  - `init`=0 → IDLE. Otherwise stay in INIT.
  - `err` is ignored in INIT.
- IDLE:
  - `err` → ERROR.
  - else `init` → INIT.
  - else either FIFO non-empty → ACTIVE.
  - else stay in IDLE.
- ACTIVE:
  - `err` → ERROR.
  - else `init` → INIT.
  - else both FIFOs empty → IDLE.
  - else stay in ACTIVE.
- ERROR: sticky. Only `reset` leaves ERROR. Pops are forced to 0.
- Thresholds hold their value in every state except INIT and RESET.
- Arbitration, evaluated only in ACTIVE:
  - `elig0` = !`fifo_empty0` & !`down_almostfull0`; `elig1` = !`fifo_empty1` & !`down_almostfull1`.
  - `grant1` = `elig1` & (!`elig0` | `starve_cnt`==`STARVE_MAX`).
  - `grant0` = `elig0` & !`grant1`.
  - `pop_0` = ACTIVE & `grant0` & !`err`; `pop_1` = ACTIVE & `grant1` & !`err`.
  - At most one pop is asserted per cycle.
- `starve_cnt` (4 bits):
  - increments on `grant0` & `elig1`;
  - clears on `grant1`, on !`elig1`, and in every state other than ACTIVE;
  - never exceeds `STARVE_MAX`.
- Outputs: `idle` = (`state`==IDLE); `error_out` = (`state`==ERROR).

## Timing
- `state` and the threshold registers are Moore registers, updated on the edge.
- The pop strobes are combinational (Mealy) from the registered `state` and the current-cycle flags. A FIFO holding exactly one word is popped once: its empty flag rises before the next evaluation.
- IDLE → ACTIVE takes one cycle. The first pop is possible in the cycle after `fifo_empty*` falls in IDLE.
- An `init` assertion in ACTIVE suppresses pops from the next cycle, because `state` is then INIT.
- `err` in ACTIVE suppresses pops in the same cycle. `state`=ERROR one edge later.
- `reset` in mid-operation: the next edge gives RESET, thresholds 0 and pops 0, regardless of state.
- `down_almostfull*` rising in the same cycle as a non-empty FIFO blocks that FIFO's pop in that cycle. The other FIFO may be granted in the same cycle.
- Steady state, both paths eligible, `STARVE_MAX`=4: the grant sequence is P0,P0,P0,P0,P1, repeating with period 5.

## Test plan
- Reset sequence: `reset`=1 for 2 cycles, then 0 with `init`=1 and thresholds 5/2 for 3 cycles, then `init`=0. Expected: `state` goes 0 → 1; `th_almost_full`=5 and `th_almost_empty`=2; `state`=2 and `idle`=1 one edge after `init` falls.
- Both FIFOs continuously non-empty, no backpressure, 20 ACTIVE cycles. Expected: `pop_0` is 1 in 16 cycles and `pop_1` is 1 in 4 cycles; a `pop_1` occurs every 5th cycle; the two pops are never high together.
- `down_almostfull0`=1 with both FIFOs non-empty. Expected: `pop_1`=1 every cycle and `pop_0`=0. When `down_almostfull0` falls, `pop_0` resumes the same cycle and `starve_cnt` restarts from 0.
- Single word in fifo1 only, from IDLE. Expected: `state`=ACTIVE next edge; `pop_1` pulses once for 1 cycle; `fifo_empty1` rises; `state`=IDLE one edge later.
- `fifo_error0` pulsed for 1 cycle in ACTIVE while `pop_0` would be granted. Expected: `pop_0`=0 that cycle; `state`=4 and `error_out`=1 next edge and held after the pulse; recovery only through `reset`, with `state`=0 and thresholds 0.
- `init`=1 asserted mid-ACTIVE with new thresholds 6/1. Expected: pops are 0 from the next cycle; thresholds update to 6/1; `state` returns to IDLE and then ACTIVE after `init` falls while the FIFOs are non-empty.
